// File: rtl/motion_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | motion_sequencer_if : frame, button, speed and sprite-control bundle       |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
interface motion_sequencer_if;
  logic       frame_start;
  logic       btn_r;
  logic       btn_l;
  logic       btn_p;
  logic [1:0] speed;
  logic       refr_tick;
  logic [3:0] dir;
  logic       turn_pending;
  logic       paused;

  modport slave (
    input  frame_start, btn_r, btn_l, btn_p, speed,
    output refr_tick, dir, turn_pending, paused
  );

  modport master (
    output frame_start, btn_r, btn_l, btn_p, speed,
    input  refr_tick, dir, turn_pending, paused
  );
endinterface
`default_nettype wire

// File: rtl/motion_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | motion_sequencer : debounced turn/pause buttons, heading FSM, frame step   |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module motion_sequencer #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  motion_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    RIGHT = 4'b0011,
    DOWN  = 4'b1100,
    LEFT  = 4'b0001,
    UP    = 4'b0100
  } heading_e;

  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_R    = 2'd1,
    T_L    = 2'd2
  } turn_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Button index: 0 = right, 1 = left, 2 = pause
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [2:0]       armed_q, armed_d;
  logic [DEB_W-1:0] cnt_q [3];
  logic [DEB_W-1:0] cnt_d [3];
  logic [1:0]       settle_q, settle_d;
  logic [2:0]       ev;

  heading_e   heading_q, heading_d;
  turn_e      turn_q, turn_d;
  logic       paused_q, paused_d;
  logic       refr_tick_q, refr_tick_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [3:0] fcnt_inc;
  logic [3:0] target;
  logic       step;

  function automatic heading_e turn_cw(heading_e h);
    case (h)
      RIGHT:   turn_cw = DOWN;
      DOWN:    turn_cw = LEFT;
      LEFT:    turn_cw = UP;
      default: turn_cw = RIGHT;
    endcase
  endfunction

  function automatic heading_e turn_ccw(heading_e h);
    case (h)
      RIGHT:   turn_ccw = UP;
      UP:      turn_ccw = LEFT;
      LEFT:    turn_ccw = DOWN;
      default: turn_ccw = RIGHT;
    endcase
  endfunction

  always_comb begin
    sync1_d    = {bus.btn_p, bus.btn_l, bus.btn_r};
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    armed_d    = armed_q;
    ev         = '0;
    settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + DEB_W'(1);
      end
      // A button only becomes live once it has been seen idle, so one held
      // through reset stays silent until it is released and pressed again.
      if (settle_q == 2'd2 && !sync2_q[i] && !deb_q[i] && cnt_q[i] == '0)
        armed_d[i] = 1'b1;
      ev[i] = deb_q[i] & ~deb_prev_q[i] & armed_q[i];
    end
  end

  always_comb begin
    case (bus.speed)
      2'd0:    target = 4'd8;
      2'd1:    target = 4'd4;
      2'd2:    target = 4'd2;
      default: target = 4'd1;
    endcase
    fcnt_inc = {1'b0, fcnt_q} + 4'd1;
    paused_d = paused_q ^ ev[2];
    fcnt_d   = fcnt_q;
    step     = 1'b0;
    // A pause request on this edge wins over any step it coincides with.
    if (bus.frame_start && !paused_q && !ev[2]) begin
      if (fcnt_inc >= target) begin
        fcnt_d = '0;
        step   = 1'b1;
      end else begin
        fcnt_d = fcnt_inc[2:0];
      end
    end

    heading_d = heading_q;
    if (step) begin
      case (turn_q)
        T_R:     heading_d = turn_cw(heading_q);
        T_L:     heading_d = turn_ccw(heading_q);
        default: heading_d = heading_q;
      endcase
    end

    turn_d = step ? T_NONE : turn_q;
    if (!paused_q && !ev[2] && (ev[0] ^ ev[1]) && turn_d == T_NONE)
      turn_d = ev[0] ? T_R : T_L;
    if (paused_d)
      turn_d = T_NONE;

    refr_tick_d = step;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      armed_q     <= '0;
      settle_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      heading_q   <= RIGHT;
      turn_q      <= T_NONE;
      paused_q    <= 1'b0;
      refr_tick_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      armed_q     <= armed_d;
      settle_q    <= settle_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      heading_q   <= heading_d;
      turn_q      <= turn_d;
      paused_q    <= paused_d;
      refr_tick_q <= refr_tick_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign bus.refr_tick    = refr_tick_q;
  assign bus.dir          = heading_q;
  assign bus.turn_pending = (turn_q != T_NONE);
  assign bus.paused       = paused_q;

endmodule
`default_nettype wire

// File: tb/tb_motion_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | tb_motion_sequencer : table vectors plus scoreboard of refr_tick headings  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_motion_sequencer;
  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  motion_sequencer_if bus ();

  motion_sequencer #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] exp_q [$];
  logic [3:0] ring [4];
  int         hidx_m   = 0;
  int         cnt_m    = 0;
  bit         paused_m = 1'b0;
  int         pend_m   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  logic prev_fs   = 1'b0;
  logic prev_tick = 1'b0;
  always @(negedge clk) begin
    if (rstn && bus.refr_tick === 1'b1) begin
      check("tick_after_frame", {31'd0, prev_fs}, 32'd1);
      check("tick_width", {31'd0, prev_tick}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_tick: got refr_tick=1 (dir %b), expected 0", bus.dir);
      end else begin
        check("tick_dir", {28'd0, bus.dir}, {28'd0, exp_q.pop_front()});
      end
    end
    prev_fs   = bus.frame_start;
    prev_tick = bus.refr_tick;
  end

  task automatic frame();
    @(posedge clk);
    #1 bus.frame_start = 1'b1;
    if (!paused_m) begin
      cnt_m++;
      if (cnt_m >= (8 >> bus.speed)) begin
        cnt_m = 0;
        if (pend_m == 1)      hidx_m = (hidx_m + 1) % 4;
        else if (pend_m == 2) hidx_m = (hidx_m + 3) % 4;
        pend_m = 0;
        exp_q.push_back(ring[hidx_m]);
      end
    end
    @(posedge clk);
    #1 bus.frame_start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic press(bit r, bit l, bit p, int hold);
    @(posedge clk);
    #1 {bus.btn_r, bus.btn_l, bus.btn_p} = {r, l, p};
    repeat (hold) @(posedge clk);
    #1 {bus.btn_r, bus.btn_l, bus.btn_p} = 3'b000;
    repeat (12) @(posedge clk);
    if (hold >= DEB_CYCLES) begin
      if (p) begin
        paused_m = !paused_m;
        pend_m   = 0;
      end else if (!paused_m && (r ^ l) && pend_m == 0) begin
        pend_m = r ? 1 : 2;
      end
    end
  endtask

  typedef struct {
    bit         r;
    bit         l;
    bit         p;
    int         hold;
    logic [1:0] speed;
    int         frames;
    bit         exp_pend;
    bit         exp_paused;
    logic [3:0] exp_dir;
  } vec_t;

  vec_t vecs [11];

  initial begin
    ring[0] = 4'b0011; ring[1] = 4'b1100; ring[2] = 4'b0001; ring[3] = 4'b0100;
    //            r  l  p  hold spd fr  pend paus dir
    vecs[0]  = '{0, 0, 0, 0,  2'd3, 5,  0, 0, 4'b0011};
    vecs[1]  = '{1, 0, 0, 10, 2'd3, 1,  1, 0, 4'b1100};
    vecs[2]  = '{1, 0, 0, 10, 2'd3, 1,  1, 0, 4'b0001};
    vecs[3]  = '{1, 0, 0, 10, 2'd3, 1,  1, 0, 4'b0100};
    vecs[4]  = '{1, 0, 0, 10, 2'd3, 1,  1, 0, 4'b0011};
    vecs[5]  = '{1, 0, 0, 3,  2'd3, 1,  0, 0, 4'b0011};
    vecs[6]  = '{0, 1, 0, 10, 2'd3, 1,  1, 0, 4'b0100};
    vecs[7]  = '{0, 0, 0, 0,  2'd0, 8,  0, 0, 4'b0100};
    vecs[8]  = '{0, 0, 1, 10, 2'd3, 10, 0, 1, 4'b0100};
    vecs[9]  = '{1, 0, 0, 10, 2'd3, 2,  0, 1, 4'b0100};
    vecs[10] = '{0, 0, 1, 10, 2'd3, 1,  0, 0, 4'b0100};

    bus.frame_start = 1'b0;
    bus.btn_r = 1'b0; bus.btn_l = 1'b0; bus.btn_p = 1'b0;
    bus.speed = 2'd3;

    #12;
    check("rst_dir",     {28'd0, bus.dir},          32'h3);
    check("rst_tick",    {31'd0, bus.refr_tick},    32'd0);
    check("rst_pending", {31'd0, bus.turn_pending}, 32'd0);
    check("rst_paused",  {31'd0, bus.paused},       32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].hold > 0) press(vecs[i].r, vecs[i].l, vecs[i].p, vecs[i].hold);
      @(negedge clk);
      check($sformatf("v%0d_pending", i), {31'd0, bus.turn_pending}, {31'd0, vecs[i].exp_pend});
      check($sformatf("v%0d_paused", i),  {31'd0, bus.paused},       {31'd0, vecs[i].exp_paused});
      bus.speed = vecs[i].speed;
      repeat (vecs[i].frames) frame();
      @(negedge clk);
      check($sformatf("v%0d_dir", i), {28'd0, bus.dir}, {28'd0, vecs[i].exp_dir});
    end

    // Right and left rising together cancel each other.
    press(1'b1, 1'b1, 1'b0, 10);
    @(negedge clk);
    check("both_pending", {31'd0, bus.turn_pending}, 32'd0);
    frame();
    @(negedge clk);
    check("both_dir", {28'd0, bus.dir}, 32'h4);

    // Counter at 5 under speed 0, then speed 3 must step on the next frame.
    bus.speed = 2'd0;
    repeat (5) frame();
    bus.speed = 2'd3;
    frame();
    @(negedge clk);
    check("speed_switch_step", exp_q.size(), 32'd0);

    // Asynchronous reset while paused, with btn_r held through it.
    press(1'b1, 1'b0, 1'b0, 10);
    @(negedge clk);
    check("pre_rst_pending", {31'd0, bus.turn_pending}, 32'd1);
    press(1'b0, 1'b0, 1'b1, 10);
    @(negedge clk);
    check("pre_rst_paused",  {31'd0, bus.paused},       32'd1);
    check("pause_clears_turn", {31'd0, bus.turn_pending}, 32'd0);
    @(posedge clk);
    #1 bus.btn_r = 1'b1;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_dir",    {28'd0, bus.dir},          32'h3);
    check("async_rst_paused", {31'd0, bus.paused},       32'd0);
    check("async_rst_tick",   {31'd0, bus.refr_tick},    32'd0);
    hidx_m = 0; cnt_m = 0; paused_m = 1'b0; pend_m = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("held_through_rst", {31'd0, bus.turn_pending}, 32'd0);
    frame();
    @(negedge clk);
    check("held_rst_dir", {28'd0, bus.dir}, 32'h3);
    @(posedge clk);
    #1 bus.btn_r = 1'b0;
    repeat (12) @(posedge clk);
    press(1'b1, 1'b0, 1'b0, 10);
    @(negedge clk);
    check("repress_pending", {31'd0, bus.turn_pending}, 32'd1);
    frame();
    @(negedge clk);
    check("repress_dir", {28'd0, bus.dir}, 32'hC);

    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
